niosii_system_sysid_ext: RTL and testbench

//  Parametrised system-ID/uptime slave on the Nios II Avalon-MM interconnect, next generation of the sysid block.

---
 rtl/sysid_pkg.sv | 35 +++
 rtl/sysid_prescaled_counter.sv | 50 +++++
 rtl/niosii_system_sysid_ext.sv | 127 ++++++++++++
 tb/tb_niosii_system_sysid_ext.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg
// Shared constants for the system-ID/uptime slave: register word offsets,
// CTRL bit positions, CONFIG field positions and a helper that builds the
// CONFIG word from the instance parameters.
package sysid_pkg;

    // Register word offsets on the Avalon-MM slave
    localparam logic [2:0] OFF_ID        = 3'd0;
    localparam logic [2:0] OFF_TIMESTAMP = 3'd1;
    localparam logic [2:0] OFF_VERSION   = 3'd2;
    localparam logic [2:0] OFF_UPTIME_LO = 3'd3;
    localparam logic [2:0] OFF_UPTIME_HI = 3'd4;
    localparam logic [2:0] OFF_SCRATCH   = 3'd5;
    localparam logic [2:0] OFF_CTRL      = 3'd6;
    localparam logic [2:0] OFF_CONFIG    = 3'd7;

    // CTRL register bit positions
    localparam int CTRL_FREEZE = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_OVF    = 8;

    // CONFIG register field positions
    localparam int CFG_WIDTH_LSB    = 0;
    localparam int CFG_PRESCALE_LSB = 16;

    // CONFIG = {PRESCALE[15:0], 8'd0, UPTIME_WIDTH[7:0]}
    function automatic logic [31:0] config_word(input int prescale, input int width);
        logic [31:0] w;
        w = '0;
        w[CFG_PRESCALE_LSB +: 16] = prescale[15:0];
        w[CFG_WIDTH_LSB    +: 8]  = width[7:0];
        return w;
    endfunction

endpackage

// File: rtl/sysid_prescaled_counter.sv
// sysid_prescaled_counter
// Free-running uptime counter advanced once every PRESCALE enabled clocks.
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   en         in   count enable (prescaler and counter hold when low)
//   clr        in   synchronous clear of prescaler and counter, beats increment
//   count      out  current uptime value
//   wrap_pulse out  high on the edge where the counter wraps from all-ones to 0
module sysid_prescaled_counter #(
    parameter int WIDTH    = 64,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0]      presc_q;
    logic [WIDTH-1:0] count_q;
    logic             tick;

    assign tick       = en && (presc_q == PRESCALE_LAST);
    // A clear on the same edge suppresses the increment, so no wrap either
    assign wrap_pulse = tick && !clr && (&count_q);
    assign count      = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (clr) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (en) begin
            if (tick) begin
                presc_q <= '0;
                count_q <= count_q + WIDTH'(1);
            end else begin
                presc_q <= presc_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/niosii_system_sysid_ext.sv
// niosii_system_sysid_ext
// System-ID / uptime slave on the Avalon-MM interconnect. Returns build ID,
// timestamp and version, and exposes a prescaled uptime counter with a
// coherent 64-bit readout, a scratch register and a control/status register.
// Ports:
//   clock          in   system clock
//   reset_n        in   asynchronous active-low reset
//   address        in   word offset (0..7)
//   read           in   read strobe
//   write          in   write strobe
//   writedata      in   write data
//   readdata       out  registered read data, holds when readdatavalid is low
//   readdatavalid  out  high one cycle after an accepted read
module niosii_system_sysid_ext
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'd1490891566,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          UPTIME_WIDTH = 64,
    parameter int          PRESCALE     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [31:0] CONFIG_VALUE = config_word(PRESCALE, UPTIME_WIDTH);

    logic [UPTIME_WIDTH-1:0] uptime;
    logic [63:0]             uptime_ext;
    logic                    wrap_pulse;
    logic [31:0]             shadow;
    logic [31:0]             scratch;
    logic                    freeze;
    logic                    ovf;
    logic                    write_ok;
    logic                    ctrl_write;
    logic                    clear_pulse;
    logic [31:0]             ctrl_word;
    logic [31:0]             read_mux;

    // A read in the same cycle as a write takes priority; the write is dropped
    assign write_ok    = write && !read;
    assign ctrl_write  = write_ok && (address == OFF_CTRL);
    assign clear_pulse = ctrl_write && writedata[CTRL_CLEAR];
    // Zero-extend so bits above the counter width read as 0
    assign uptime_ext  = 64'(uptime);

    sysid_prescaled_counter #(
        .WIDTH    (UPTIME_WIDTH),
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (!freeze),
        .clr        (clear_pulse),
        .count      (uptime),
        .wrap_pulse (wrap_pulse)
    );

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[CTRL_FREEZE] = freeze;
        ctrl_word[CTRL_OVF]    = ovf;
    end

    always_comb begin
        read_mux = '0;
        case (address)
            OFF_ID:        read_mux = ID_VALUE;
            OFF_TIMESTAMP: read_mux = TIMESTAMP;
            OFF_VERSION:   read_mux = VERSION;
            OFF_UPTIME_LO: read_mux = uptime_ext[31:0];
            OFF_UPTIME_HI: read_mux = shadow;
            OFF_SCRATCH:   read_mux = scratch;
            OFF_CTRL:      read_mux = ctrl_word;
            OFF_CONFIG:    read_mux = CONFIG_VALUE;
            default:       read_mux = '0;
        endcase
    end

    // Read pipeline. Reading UPTIME_LO captures the upper half on the same
    // edge, so a following UPTIME_HI read forms a coherent pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            shadow        <= '0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= read_mux;
                if (address == OFF_UPTIME_LO) begin
                    shadow <= uptime_ext[63:32];
                end
            end
        end
    end

    // Writable state. A wrap on the same edge as an OVF write-1-clear keeps OVF set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
            freeze  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (write_ok && (address == OFF_SCRATCH)) begin
                scratch <= writedata;
            end
            if (ctrl_write) begin
                freeze <= writedata[CTRL_FREEZE];
            end
            if (wrap_pulse) begin
                ovf <= 1'b1;
            end else if (ctrl_write && writedata[CTRL_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
module tb_niosii_system_sysid_ext;

    localparam int          P        = 4;
    localparam int          W        = 33;
    localparam logic [31:0] ID       = 32'd1490891566;
    localparam logic [31:0] VER      = 32'h0001_0000;
    localparam logic [31:0] CFG_MAIN = {16'd4, 8'd0, 8'd33};
    localparam logic [31:0] CFG_DEF  = {16'd1, 8'd0, 8'd64};
    localparam logic [63:0] UP_MAX   = (64'd1 << W) - 64'd1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, readdata_def;
    logic        readdatavalid, readdatavalid_def;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    logic [63:0] m_up = '0;
    int          m_phase = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_scratch = '0;
    logic        m_freeze = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_rd = '0;
    logic        m_rdv = 1'b0;
    logic [31:0] m_rd_def = '0;
    logic        def_known = 1'b1;
    logic        preload_pending = 1'b0;
    logic [63:0] preload_val = '0;

    always #5 clock = ~clock;

    niosii_system_sysid_ext #(
        .UPTIME_WIDTH (W),
        .PRESCALE     (P)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    niosii_system_sysid_ext dut_def (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata_def),
        .readdatavalid (readdatavalid_def)
    );

    // Reference model: one step per clock edge from the bus rules
    always @(posedge clock or negedge reset_n) begin : model_step
        logic [63:0] up_now, up_nxt;
        int          ph_nxt;
        logic        wr_ok, clr, wrap;
        logic [31:0] rv, rv_def;
        if (!reset_n) begin
            m_up <= '0; m_phase <= 0; m_shadow <= '0; m_scratch <= '0;
            m_freeze <= 1'b0; m_ovf <= 1'b0; m_rd <= '0; m_rdv <= 1'b0;
            m_rd_def <= '0; def_known <= 1'b1;
        end else begin
            up_now = preload_pending ? preload_val : m_up;
            wr_ok  = write && !read;
            clr    = wr_ok && (address == 3'd6) && writedata[1];
            wrap   = 1'b0;
            up_nxt = up_now;
            ph_nxt = m_phase;
            if (clr) begin
                up_nxt = '0;
                ph_nxt = 0;
            end else if (!m_freeze) begin
                if (m_phase == P - 1) begin
                    ph_nxt = 0;
                    if (up_now == UP_MAX) begin
                        up_nxt = '0;
                        wrap   = 1'b1;
                    end else begin
                        up_nxt = up_now + 64'd1;
                    end
                end else begin
                    ph_nxt = m_phase + 1;
                end
            end
            case (address)
                3'd0: rv = ID;
                3'd1: rv = 32'd0;
                3'd2: rv = VER;
                3'd3: rv = up_now[31:0];
                3'd4: rv = m_shadow;
                3'd5: rv = m_scratch;
                3'd6: rv = {23'd0, m_ovf, 7'd0, m_freeze};
                default: rv = CFG_MAIN;
            endcase
            rv_def = rv;
            if (address == 3'd6) rv_def = {23'd0, 1'b0, 7'd0, m_freeze};
            if (address == 3'd7) rv_def = CFG_DEF;
            m_rdv <= read;
            if (read) begin
                m_rd <= rv;
                if (address == 3'd3) m_shadow <= up_now[63:32];
                if (address == 3'd3 || address == 3'd4) begin
                    def_known <= 1'b0;
                end else begin
                    def_known <= 1'b1;
                    m_rd_def  <= rv_def;
                end
            end
            if (wr_ok && address == 3'd5) m_scratch <= writedata;
            if (wr_ok && address == 3'd6) m_freeze <= writedata[0];
            if (wrap) m_ovf <= 1'b1;
            else if (wr_ok && address == 3'd6 && writedata[8]) m_ovf <= 1'b0;
            m_up    <= up_nxt;
            m_phase <= ph_nxt;
        end
    end

    // Compare process: outputs against the model on every falling edge
    always @(negedge clock) begin
        n_checks++;
        if (readdatavalid !== m_rdv) begin
            n_fails++;
            $display("[TB] FAIL rdv_main: got %b want %b at %0t", readdatavalid, m_rdv, $time);
        end
        n_checks++;
        if (readdata !== m_rd) begin
            n_fails++;
            $display("[TB] FAIL rd_main: got %h want %h at %0t", readdata, m_rd, $time);
        end
        n_checks++;
        if (readdatavalid_def !== m_rdv) begin
            n_fails++;
            $display("[TB] FAIL rdv_def: got %b want %b at %0t", readdatavalid_def, m_rdv, $time);
        end
        if (def_known) begin
            n_checks++;
            if (readdata_def !== m_rd_def) begin
                n_fails++;
                $display("[TB] FAIL rd_def: got %h want %h at %0t", readdata_def, m_rd_def, $time);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs now (just after a falling edge), return at next falling edge
    task automatic applyStimulus(input logic [2:0] a, input logic r, input logic w, input logic [31:0] d);
        address   = a;
        read      = r;
        write     = w;
        writedata = d;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(3'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic readReg(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d_def);
        applyStimulus(a, 1'b1, 1'b0, 32'd0);
        d     = readdata;
        d_def = readdata_def;
        checkOutput("rdv_after_read", {31'd0, readdatavalid}, 32'd1);
        read  = 1'b0;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(a, 1'b0, 1'b1, d);
        write = 1'b0;
    endtask

    // Idle until the next edge is an uptime increment edge
    task automatic waitIncEdge();
        for (int i = 0; i < 2 * P && m_phase != P - 1; i++) idle(1);
        checkOutput("inc_edge_found", m_phase, P - 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] d, dd, frozen;
        #1 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_rdv", {31'd0, readdatavalid}, 32'd0);
        checkOutput("reset_rd", readdata, 32'd0);
        reset_n = 1'b1;

        // Identity registers
        readReg(3'd0, d, dd); checkOutput("id_main", d, 32'd1490891566); checkOutput("id_def", dd, 32'd1490891566);
        readReg(3'd1, d, dd); checkOutput("ts_def", dd, 32'd0);
        readReg(3'd2, d, dd); checkOutput("ver_def", dd, 32'h0001_0000);
        readReg(3'd7, d, dd); checkOutput("cfg_def", dd, 32'h0001_0040); checkOutput("cfg_main", d, 32'h0004_0021);
        idle(1);
        checkOutput("rdv_one_cycle", {31'd0, readdatavalid}, 32'd0);

        // Prescaled counting from a fresh reset
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        idle(40);
        readReg(3'd3, d, dd);
        n_checks++;
        if (d < 32'd9 || d > 32'd11) begin
            n_fails++;
            $display("[TB] FAIL uptime_40clk: got %0d want 9..11", d);
        end

        // Freeze holds the counter
        writeReg(3'd6, 32'h1);
        frozen = m_up[31:0];
        idle(100);
        readReg(3'd3, d, dd); checkOutput("freeze_hold", d, frozen);
        readReg(3'd6, d, dd); checkOutput("ctrl_freeze", d, 32'h1);
        writeReg(3'd6, 32'h0);

        // Scratch and read-only behaviour
        writeReg(3'd5, 32'hDEAD_BEEF);
        readReg(3'd5, d, dd); checkOutput("scratch_rb", d, 32'hDEAD_BEEF);
        writeReg(3'd0, 32'h1234_5678);
        readReg(3'd0, d, dd); checkOutput("id_ro", d, 32'd1490891566);
        applyStimulus(3'd5, 1'b1, 1'b1, 32'h0BAD_F00D);
        read = 1'b0; write = 1'b0;
        checkOutput("rw_same_old", readdata, 32'hDEAD_BEEF);
        readReg(3'd5, d, dd); checkOutput("rw_same_kept", d, 32'hDEAD_BEEF);

        // Coherent readout and wrap at the 33-bit boundary
        waitIncEdge();
        force dut.u_counter.count_q = 33'h1_FFFF_FFFF;
        preload_val = 64'h1_FFFF_FFFF;
        preload_pending = 1'b1;
        #1 release dut.u_counter.count_q;
        readReg(3'd3, d, dd);
        preload_pending = 1'b0;
        checkOutput("lo_at_max", d, 32'hFFFF_FFFF);
        readReg(3'd4, d, dd); checkOutput("hi_shadow", d, 32'h1);
        readReg(3'd6, d, dd); checkOutput("ovf_set", d, 32'h100);

        // CLEAR on an increment edge
        waitIncEdge();
        writeReg(3'd6, 32'h2);
        readReg(3'd3, d, dd);
        n_checks++;
        if (d > 32'd2) begin
            n_fails++;
            $display("[TB] FAIL clear_lo: got %0d want <=2", d);
        end
        readReg(3'd6, d, dd); checkOutput("ctrl_after_clear", d, 32'h100);
        writeReg(3'd6, 32'h100);
        readReg(3'd6, d, dd); checkOutput("ovf_w1c", d, 32'h0);

        // Randomised traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd6) wd = wd & (($urandom_range(0, 7) == 0) ? 32'h103 : 32'h101);
            applyStimulus(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), wd);
        end
        idle(2);

        // Reset during a read
        writeReg(3'd5, 32'hCAFE_0001);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'd0);
        read = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_rdv", {31'd0, readdatavalid}, 32'd0);
        checkOutput("mid_reset_rd", readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        readReg(3'd5, d, dd); checkOutput("post_reset_scratch", d, 32'd0);
        readReg(3'd6, d, dd); checkOutput("post_reset_ctrl", d, 32'd0);
        readReg(3'd4, d, dd); checkOutput("post_reset_hi", d, 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
